// File: rtl/cdb_arbiter_if.sv
// Common-data-bus bundle: requester result slices in, registered broadcast out.
// Requester slice i of every packed vector belongs to requester i.
interface cdb_arbiter_if #(
    parameter int NUM_REQ   = 3,
    parameter int ROB_WIDTH = 4,
    parameter int IDX_WIDTH = 2
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*ROB_WIDTH-1:0] req_tag;
    logic [NUM_REQ*3-1:0]         req_op;
    logic [NUM_REQ-1:0]           req_done;
    logic [NUM_REQ*5-1:0]         req_rd;
    logic [NUM_REQ*32-1:0]        req_wdata;
    logic [NUM_REQ*32-1:0]        req_jump;

    logic                         wb_valid;
    logic [IDX_WIDTH-1:0]         wb_src;
    logic [ROB_WIDTH-1:0]         wb_tag;
    logic [2:0]                   wb_op;
    logic                         wb_done;
    logic [4:0]                   wb_rd;
    logic [31:0]                  wb_wdata;
    logic [31:0]                  wb_jump;

    // Producer / consumer side (execution units and ROB/RS).
    modport master (
        output req_valid, req_tag, req_op, req_done, req_rd, req_wdata, req_jump,
        input  req_ready,
        input  wb_valid, wb_src, wb_tag, wb_op, wb_done, wb_rd, wb_wdata, wb_jump
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_tag, req_op, req_done, req_rd, req_wdata, req_jump,
        output req_ready,
        output wb_valid, wb_src, wb_tag, wb_op, wb_done, wb_rd, wb_wdata, wb_jump
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single common-data-bus writeback slot.
// One requester wins per cycle; its result is registered and broadcast to
// the ROB and reservation stations one cycle later. A stalled broadcast is
// held, a mispredict clear drops it and rewinds the round-robin pointer.
module cdb_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ROB_WIDTH = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       rdy_in,
    input  logic       clear_in,
    input  logic       stall_in,
    output logic [7:0] busy_cnt,
    cdb_arbiter_if.slave bus
);

    logic                 r_wb_valid;
    logic [IDX_WIDTH-1:0] r_wb_src;
    logic [ROB_WIDTH-1:0] r_wb_tag;
    logic [2:0]           r_wb_op;
    logic                 r_wb_done;
    logic [4:0]           r_wb_rd;
    logic [31:0]          r_wb_wdata;
    logic [31:0]          r_wb_jump;
    logic [IDX_WIDTH-1:0] r_rr_ptr;
    logic [7:0]           r_busy_cnt;

    logic [NUM_REQ-1:0]   w_scan_vec;
    logic [IDX_WIDTH-1:0] w_scan_idx;
    logic                 w_scan_any;
    logic                 w_block;
    logic                 w_grant_any;
    logic [NUM_REQ-1:0]   w_ready;
    logic                 w_refused;
    logic [IDX_WIDTH-1:0] w_next_ptr;

    logic [ROB_WIDTH-1:0] w_sel_tag;
    logic [2:0]           w_sel_op;
    logic                 w_sel_done;
    logic [4:0]           w_sel_rd;
    logic [31:0]          w_sel_wdata;
    logic [31:0]          w_sel_jump;

    // Find the first valid requester starting at the round-robin pointer.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        w_scan_vec = '0;
        w_scan_idx = '0;
        w_scan_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_scan_any && bus.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_scan_any = 1'b1;
                w_scan_idx = IDX_WIDTH'((int'(r_rr_ptr) + k) % NUM_REQ);
                w_scan_vec[(int'(r_rr_ptr) + k) % NUM_REQ] = 1'b1;
            end
        end
    end

    // No grant in reset, when disabled, on a flush, or while a broadcast is stalled.
    assign w_block     = !rst_n_in || !rdy_in || clear_in || (stall_in && r_wb_valid);
    assign w_grant_any = w_scan_any && !w_block;
    assign w_ready     = w_block ? '0 : w_scan_vec;
    assign w_refused   = |(bus.req_valid & ~w_ready);
    assign w_next_ptr  = (int'(w_scan_idx) == NUM_REQ - 1) ? '0 : w_scan_idx + IDX_WIDTH'(1);

    assign w_sel_tag   = bus.req_tag  [int'(w_scan_idx)*ROB_WIDTH +: ROB_WIDTH];
    assign w_sel_op    = bus.req_op   [int'(w_scan_idx)*3  +: 3];
    assign w_sel_done  = bus.req_done [w_scan_idx];
    assign w_sel_rd    = bus.req_rd   [int'(w_scan_idx)*5  +: 5];
    assign w_sel_wdata = bus.req_wdata[int'(w_scan_idx)*32 +: 32];
    assign w_sel_jump  = bus.req_jump [int'(w_scan_idx)*32 +: 32];

    // Broadcast register and round-robin pointer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            // NOTE: the data fields are reset too because the broadcast is visible to the ROB/RS straight out of reset.
            r_wb_valid <= 1'b0;
            r_wb_src   <= '0;
            r_wb_tag   <= '0;
            r_wb_op    <= '0;
            r_wb_done  <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_wdata <= '0;
            r_wb_jump  <= '0;
            r_rr_ptr   <= '0;
        end else if (rdy_in) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (clear_in) begin
                r_wb_valid <= 1'b0;
                r_rr_ptr   <= '0;
            end else if (stall_in && r_wb_valid) begin
                // Downstream busy: hold the pending broadcast untouched.
            end else if (w_grant_any) begin
                r_wb_valid <= 1'b1;
                r_wb_src   <= w_scan_idx;
                r_wb_tag   <= w_sel_tag;
                r_wb_op    <= w_sel_op;
                r_wb_done  <= w_sel_done;
                r_wb_rd    <= w_sel_rd;
                r_wb_wdata <= w_sel_wdata;
                r_wb_jump  <= w_sel_jump;
                r_rr_ptr   <= w_next_ptr;
            end else begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    // Saturating count of cycles in which some valid requester was refused.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_busy_cnt <= '0;
        end else if (rdy_in && w_refused && (r_busy_cnt != 8'hFF)) begin
            r_busy_cnt <= r_busy_cnt + 8'd1;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wb_valid  = r_wb_valid;
    assign bus.wb_src    = r_wb_src;
    assign bus.wb_tag    = r_wb_tag;
    assign bus.wb_op     = r_wb_op;
    assign bus.wb_done   = r_wb_done;
    assign bus.wb_rd     = r_wb_rd;
    assign bus.wb_wdata  = r_wb_wdata;
    assign bus.wb_jump   = r_wb_jump;
    assign busy_cnt      = r_busy_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_cdb_arbiter;
    localparam int N  = 3;
    localparam int RW = 4;
    localparam int IW = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdy   = 1'b1;
    logic       clear = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] busy_cnt;

    cdb_arbiter_if #(.NUM_REQ(N), .ROB_WIDTH(RW), .IDX_WIDTH(IW)) bus ();

    cdb_arbiter #(.NUM_REQ(N), .ROB_WIDTH(RW), .IDX_WIDTH(IW)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .clear_in (clear),
        .stall_in (stall),
        .busy_cnt (busy_cnt),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [RW-1:0] tag;
        logic [2:0]    op;
        logic          done;
        logic [4:0]    rd;
        logic [31:0]   wdata;
        logic [31:0]   jump;
    } beat_t;

    bit    m_valid = 1'b0;
    int    m_src   = 0;
    beat_t m_beat  = '0;
    int    m_ptr   = 0;
    int    m_busy  = 0;

    function automatic beat_t req_beat(input int i);
        beat_t b;
        b.tag   = bus.req_tag[i*RW +: RW];
        b.op    = bus.req_op[i*3 +: 3];
        b.done  = bus.req_done[i];
        b.rd    = bus.req_rd[i*5 +: 5];
        b.wdata = bus.req_wdata[i*32 +: 32];
        b.jump  = bus.req_jump[i*32 +: 32];
        return b;
    endfunction

    // Which requester wins right now, or -1 for nobody.
    function automatic int pick();
        if (!rst_n || !rdy || clear || (stall && m_valid)) return -1;
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] ready_of(input int g);
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_src   = 0;
            m_beat  = '0;
            m_ptr   = 0;
            m_busy  = 0;
        end else if (rdy) begin
            int g;
            g = pick();
            if (((bus.req_valid & ~ready_of(g)) != '0) && m_busy < 255) m_busy++;
            if (clear) begin
                m_valid = 1'b0;
                m_ptr   = 0;
            end else if (stall && m_valid) begin
                m_valid = m_valid;
            end else if (g >= 0) begin
                m_valid = 1'b1;
                m_src   = g;
                m_beat  = req_beat(g);
                m_ptr   = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    // Every-cycle comparison, sampled away from the rising edge.
    always @(negedge clk) begin
        check("req_ready", 64'(bus.req_ready), 64'(ready_of(pick())));
        check("wb_valid",  64'(bus.wb_valid),  64'(m_valid));
        check("wb_src",    64'(bus.wb_src),    64'(m_src));
        check("wb_tag",    64'(bus.wb_tag),    64'(m_beat.tag));
        check("wb_op",     64'(bus.wb_op),     64'(m_beat.op));
        check("wb_done",   64'(bus.wb_done),   64'(m_beat.done));
        check("wb_rd",     64'(bus.wb_rd),     64'(m_beat.rd));
        check("wb_wdata",  64'(bus.wb_wdata),  64'(m_beat.wdata));
        check("wb_jump",   64'(bus.wb_jump),   64'(m_beat.jump));
        check("busy_cnt",  64'(busy_cnt),      64'(m_busy));
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input int i, input logic v, input logic [RW-1:0] tag,
                           input logic [2:0] op, input logic done, input logic [4:0] rd,
                           input logic [31:0] wd, input logic [31:0] jp);
        bus.req_valid[i]           = v;
        bus.req_tag[i*RW +: RW]    = tag;
        bus.req_op[i*3 +: 3]       = op;
        bus.req_done[i]            = done;
        bus.req_rd[i*5 +: 5]       = rd;
        bus.req_wdata[i*32 +: 32]  = wd;
        bus.req_jump[i*32 +: 32]   = jp;
    endtask

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] acc;
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_op    = '0;
        bus.req_done  = '0;
        bus.req_rd    = '0;
        bus.req_wdata = '0;
        bus.req_jump  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_wb_valid", 64'(bus.wb_valid),  64'h0);
        check("reset_busy",     64'(busy_cnt),      64'h0);
        check("reset_ready",    64'(bus.req_ready), 64'h0);
        drive_point();
        rst_n = 1'b1;
        drive_point();

        // Lone requester 1
        set_req(1, 1'b1, 4'd5, 3'd1, 1'b1, 5'd3, 32'hDEADBEEF, 32'h0);
        @(negedge clk);
        check("t2_ready", 64'(bus.req_ready), 64'h2);
        drive_point();
        check("t2_wb_valid", 64'(bus.wb_valid), 64'h1);
        check("t2_wb_src",   64'(bus.wb_src),   64'h1);
        check("t2_wb_tag",   64'(bus.wb_tag),   64'h5);
        check("t2_wb_rd",    64'(bus.wb_rd),    64'h3);
        check("t2_wb_wdata", 64'(bus.wb_wdata), 64'hDEADBEEF);

        // Pointer now at 2: requester 2 wins among all three
        set_req(0, 1'b1, 4'd1, 3'd1, 1'b1, 5'd1, 32'h11, 32'h0);
        set_req(1, 1'b1, 4'd6, 3'd1, 1'b1, 5'd6, 32'h66, 32'h0);
        set_req(2, 1'b1, 4'd9, 3'd2, 1'b1, 5'd0, 32'h0,  32'h1000);
        @(negedge clk);
        check("t2_next_ready", 64'(bus.req_ready), 64'h4);
        drive_point();
        check("t3_wb_src",  64'(bus.wb_src),  64'h2);
        check("t3_wb_jump", 64'(bus.wb_jump), 64'h1000);
        check("t3_busy0",   64'(busy_cnt),    64'h1);

        // Stall the pending broadcast for three cycles
        bus.req_valid[2] = 1'b0;
        stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_stall_ready", 64'(bus.req_ready), 64'h0);
            drive_point();
            check("t3_hold_valid", 64'(bus.wb_valid), 64'h1);
            check("t3_hold_src",   64'(bus.wb_src),   64'h2);
            check("t3_hold_jump",  64'(bus.wb_jump),  64'h1000);
        end
        check("t3_busy_stall", 64'(busy_cnt), 64'h4);
        stall = 1'b0;
        @(negedge clk);
        check("t3_release_ready", 64'(bus.req_ready), 64'h1);
        drive_point();
        check("t3_release_src", 64'(bus.wb_src), 64'h0);
        check("t3_busy_rel",    64'(busy_cnt),   64'h5);

        // Flush while a stalled broadcast is pending
        bus.req_valid[0] = 1'b0;
        stall = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        check("t4_clear_ready", 64'(bus.req_ready), 64'h0);
        drive_point();
        check("t4_wb_valid", 64'(bus.wb_valid), 64'h0);
        check("t4_busy",     64'(busy_cnt),     64'h6);
        clear = 1'b0;
        stall = 1'b0;
        bus.req_valid[0] = 1'b1;
        @(negedge clk);
        check("t4_ptr_rewound", 64'(bus.req_ready), 64'h1);
        drive_point();
        check("t4_wb_src", 64'(bus.wb_src), 64'h0);
        check("t4_busy2",  64'(busy_cnt),   64'h7);

        // Asynchronous reset in the middle of a broadcast
        bus.req_valid[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 64'(bus.wb_valid),  64'h0);
        check("t5_async_busy",  64'(busy_cnt),      64'h0);
        check("t5_async_ready", 64'(bus.req_ready), 64'h0);
        drive_point();
        rst_n = 1'b1;
        bus.req_valid = 3'b111;

        // All three continuously valid: 0,1,2,0
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t1_ready", 64'(bus.req_ready), 64'(N'(1) << (c % 3)));
            drive_point();
            check("t1_wb_valid", 64'(bus.wb_valid), 64'h1);
            check("t1_wb_src",   64'(bus.wb_src),   64'(c % 3));
        end

        // Saturation: a refused requester every cycle for 300 cycles
        bus.req_valid = 3'b011;
        repeat (300) drive_point();
        check("t6_busy_sat", 64'(busy_cnt), 64'hFF);

        // Randomized traffic honouring the hold-until-accepted protocol
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            drive_point();
            if (cyc == 1500) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            rdy   = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !bus.req_valid[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, 1'b1, RW'($urandom), 3'($urandom), 1'($urandom),
                                5'($urandom), $urandom, $urandom);
                    else
                        bus.req_valid[i] = 1'b0;
                end
            end
        end

        bus.req_valid = '0;
        rdy   = 1'b1;
        stall = 1'b0;
        clear = 1'b0;
        repeat (2) drive_point();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single common-data-bus writeback slot between NUM_REQ producers: ALU reservation station, load/store buffer and branch unit.
- The granted result is registered and broadcast to the ROB (result write) and the RS (operand wakeup).
- Uses round-robin fairness, a downstream stall and a synchronous flush on mispredict clear.
- Sits between execution units and the ROB/RS, replacing the separate per-unit writeback ports.

Parameters:
NUM_REQ, 3, number of requesters (>=2); index 0 = ALU, 1 = LSB, 2 = branch
ROB_WIDTH, 4, ROB tag width
IDX_WIDTH, 2, width of requester index (>= clog2(NUM_REQ))

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global enable; when low, all state holds
clear_in  input  1  mispredict flush from ROB, synchronous
stall_in  input  1  downstream cannot accept a broadcast this cycle
req_valid  input  NUM_REQ  per-requester result valid
req_ready  output  NUM_REQ  combinational grant; a transfer occurs when valid&ready
req_tag  input  NUM_REQ*ROB_WIDTH  ROB tag per requester (slice i)
req_op  input  NUM_REQ*3  commit op code (WRITE/JUMP/BOTH/LS/NOTHING)
req_done  input  NUM_REQ  entry ready-to-commit flag
req_rd  input  NUM_REQ*5  destination register
req_wdata  input  NUM_REQ*32  result data
req_jump  input  NUM_REQ*32  jump target
wb_valid  output  1  broadcast valid (registered)
wb_src  output  IDX_WIDTH  index of granted requester
wb_tag  output  ROB_WIDTH  broadcast tag
wb_op  output  3  broadcast op
wb_done  output  1  broadcast ready flag
wb_rd  output  5  broadcast rd
wb_wdata  output  32  broadcast data
wb_jump  output  32  broadcast jump target
busy_cnt  output  8  saturating count of cycles with >=1 valid requester refused

Behaviour:
- Reset (rst_n_in low, asynchronous): wb_valid=0; wb_src, wb_tag, wb_op, wb_done, wb_rd, wb_wdata, wb_jump all 0; rr_ptr=0; busy_cnt=0. req_ready=0 while reset is asserted.
- rdy_in low: no register changes; req_ready forced 0.
- Arbitration (combinational):
  - If clear_in=1, or stall_in=1 with wb_valid=1, then req_ready=0.
  - Otherwise grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. At most one req_ready bit is high per cycle.
- Output register (1-cycle latency), on each clock edge with rdy_in=1:
  - clear_in=1: wb_valid<=0, rr_ptr<=0. Any in-flight broadcast is dropped, even if stall_in is high.
  - stall_in=1 and wb_valid=1: hold all wb_* outputs.
  - Grant to requester g: wb_valid<=1, wb_src<=g, and wb_* fields <= slice g. rr_ptr <= (g+1) mod NUM_REQ (wraps from NUM_REQ-1 to 0).
  - No grant: wb_valid<=0; data fields hold their last value.
- stall_in with wb_valid=0 has no effect on grants; the empty slot accepts.
- busy_cnt increments when rdy_in=1 and any req_valid bit has req_ready=0, including during clear and stall. It saturates at 255 and is never cleared except by reset.
- Requesters must hold valid and all fields stable until accepted. The arbiter does not buffer refused requests.
- Reset asserted mid-broadcast aborts it; wb_valid falls asynchronously.

Test Plan:
1. All three requesters valid continuously, rr_ptr=0, no stall -> grants in order 0,1,2,0,...; wb_valid=1 every cycle from cycle 1; wb_src follows the grant sequence one cycle late.
2. Only req 1 valid (tag=5, op=WRITE, rd=3, wdata=0xDEADBEEF) -> req_ready=0b010 the same cycle; next cycle wb_valid=1, wb_tag=5, wb_rd=3, wb_wdata=0xDEADBEEF; rr_ptr=2.
3. Broadcast of req 2 (jump=0x1000) pending, stall_in=1 for 3 cycles -> wb_* held unchanged for 3 cycles, req_ready=0, busy_cnt increases by 3 with requesters valid; release -> next grant is req 0.
4. clear_in=1 while wb_valid=1 and stall_in=1 -> next cycle wb_valid=0 and rr_ptr=0; req_ready=0 during the clear cycle.
5. rst_n_in driven low asynchronously mid-cycle with wb_valid=1 -> wb_valid=0 immediately, busy_cnt=0; after release, the first grant goes to req 0.
6. Req 0 valid with no stall and req 1 refused for 300 cycles -> busy_cnt saturates at 255.
